// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter and register scoreboard.
// Serialises ALU results (unbuffered) and load results (queued) onto the
// single register-file write port. Tracks per-register pending writes so
// decode can stall until a value is readable.
module wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            iss_set,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    output logic            busy1,
    output logic            busy2,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_wdata,
    output logic            idle
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    // Load queue storage (no reset needed; validity is tracked by count_reg)
    logic [4:0]      lq_rd   [LQ_DEPTH];
    logic [XLEN-1:0] lq_data [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    logic            win_valid;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;

    logic [31:1]     pending_reg;
    logic [31:0]     pending;

    assign full     = (count_reg == CW'(LQ_DEPTH));
    assign empty    = (count_reg == '0);
    assign ld_ready = !full;
    assign push     = ld_valid && !full;

    // Arbitration: a full queue forces the load head out first; otherwise
    // the ALU has priority since it cannot buffer its result.
    always_comb begin
        alu_ready = !full;
        win_valid = 1'b0;
        win_rd    = '0;
        win_data  = '0;
        pop       = 1'b0;
        if (full) begin
            win_valid = 1'b1;
            win_rd    = lq_rd[rd_ptr_reg];
            win_data  = lq_data[rd_ptr_reg];
            pop       = 1'b1;
        end else if (alu_valid) begin
            win_valid = 1'b1;
            win_rd    = alu_rd;
            win_data  = alu_data;
        end else if (!empty) begin
            win_valid = 1'b1;
            win_rd    = lq_rd[rd_ptr_reg];
            win_data  = lq_data[rd_ptr_reg];
            pop       = 1'b1;
        end
    end

    // Queue entry write on push
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[wr_ptr_reg]   <= ld_rd;
            lq_data[wr_ptr_reg] <= ld_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered write port; a winner targeting x0 is consumed silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_wdata <= '0;
        end else begin
            wb_we <= win_valid && (win_rd != 5'd0);
            if (win_valid) begin
                wb_rd    <= win_rd;
                wb_wdata <= win_data;
            end
        end
    end

    // Scoreboard bits for x1..x31; a fresh issue beats a same-edge writeback
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_pend
            // Per-register pending flag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pending_reg[gi] <= 1'b0;
                end else if (iss_set && (iss_rd == 5'(gi))) begin
                    pending_reg[gi] <= 1'b1;
                end else if (wb_we && (wb_rd == 5'(gi))) begin
                    pending_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign pending = {pending_reg, 1'b0};
    assign busy1   = pending[chk_rs1];
    assign busy2   = pending[chk_rs2];
    assign idle    = empty && (pending_reg == '0) && !wb_we;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus a random mixed stream,
// all checked against a queue-based behavioural model.
module tb_wb_arbiter;
    localparam int XLEN = 32;
    localparam int D    = 2;

    logic            clk;
    logic            rst_n;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            iss_set;
    logic [4:0]      iss_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic            busy1;
    logic            busy2;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_wdata;
    logic            idle;

    wb_arbiter #(.XLEN(XLEN), .LQ_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_set(iss_set), .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .busy1(busy1), .busy2(busy2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of loads, a pending bitmap, and the write port
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    logic [31:0]     m_pend;
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    logic            m_alu_acc;
    logic            m_ld_acc;

    function automatic logic m_idle();
        return (mq.size() == 0) && (m_pend == 32'd0) && !m_we;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend    = '0;
        m_we      = 1'b0;
        m_rd      = '0;
        m_data    = '0;
        m_alu_acc = 1'b0;
        m_ld_acc  = 1'b0;
    endtask

    task automatic model_step();
        logic            full;
        logic            wv;
        logic [4:0]      wr;
        logic [XLEN-1:0] wd;
        full      = (mq.size() == D);
        wv        = 1'b0;
        wr        = '0;
        wd        = '0;
        m_alu_acc = 1'b0;
        m_ld_acc  = 1'b0;
        if (full || (!alu_valid && mq.size() > 0)) begin
            wv = 1'b1;
            wr = mq[0].rd;
            wd = mq[0].data;
            void'(mq.pop_front());
        end else if (alu_valid) begin
            wv = 1'b1;
            wr = alu_rd;
            wd = alu_data;
            m_alu_acc = 1'b1;
        end
        if (ld_valid && !full) begin
            ent_t e;
            e.rd   = ld_rd;
            e.data = ld_data;
            mq.push_back(e);
            m_ld_acc = 1'b1;
        end
        if (m_we) m_pend[m_rd] = 1'b0;
        if (iss_set && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
        m_we = wv && (wr != 5'd0);
        if (wv) begin
            m_rd   = wr;
            m_data = wd;
        end
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model at the edge
    task automatic cycle();
        @(negedge clk);
        check("alu_ready", alu_ready, mq.size() < D);
        check("ld_ready", ld_ready, mq.size() < D);
        check("busy1", busy1, m_pend[chk_rs1]);
        check("busy2", busy2, m_pend[chk_rs2]);
        check("idle", idle, m_idle());
        check("wb_we", wb_we, m_we);
        if (m_we) begin
            check("wb_rd", wb_rd, m_rd);
            check("wb_wdata", wb_wdata, m_data);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        iss_set = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    endtask

    initial begin
        int produced;
        int cyc;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #3;
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_wdata", wb_wdata, 0);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_idle", idle, 1);
        #9 rst_n = 1'b1;
        cycle();
        cycle();

        // ALU latency
        iss_set = 1; iss_rd = 7; chk_rs1 = 7;
        cycle();
        iss_set = 0;
        check("alu_busy_before", busy1, 1);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h12345678;
        cycle();
        alu_valid = 0;
        check("alu_we_n1", wb_we, 1);
        check("alu_rd_n1", wb_rd, 7);
        check("alu_data_n1", wb_wdata, 32'h12345678);
        check("alu_busy_n1", busy1, 1);
        cycle();
        check("alu_we_n2", wb_we, 0);
        check("alu_busy_n2", busy1, 0);

        // x0 discard
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
        iss_set = 1; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        check("x0_alu_ready", alu_ready, 1);
        cycle();
        alu_valid = 0; iss_set = 0;
        check("x0_we", wb_we, 0);
        check("x0_busy", busy1, 0);
        cycle();
        check("x0_we_after", wb_we, 0);

        // Set/clear collision on x9
        iss_set = 1; iss_rd = 9; chk_rs1 = 9; chk_rs2 = 9;
        cycle();
        iss_set = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h0000_0909;
        cycle();
        alu_valid = 0;
        iss_set = 1; iss_rd = 9;
        check("coll_we", wb_we, 1);
        cycle();
        iss_set = 0;
        check("coll_busy1", busy1, 1);
        check("coll_busy2", busy2, 1);
        alu_valid = 1; alu_rd = 9; alu_data = 32'h0000_0999;
        cycle();
        alu_valid = 0;
        cycle();
        check("coll_cleared", busy1, 0);

        // Full-queue priority with ALU held valid
        alu_valid = 1; alu_rd = 10; alu_data = 32'hC0DE;
        ld_valid = 1; ld_rd = 3; ld_data = 32'hA;
        cycle();
        ld_rd = 4; ld_data = 32'hB;
        cycle();
        ld_valid = 0;
        check("fq_alu_stalled", alu_ready, 0);
        cycle();
        check("fq_first_rd", wb_rd, 3);
        check("fq_first_data", wb_wdata, 32'hA);
        check("fq_alu_ready_back", alu_ready, 1);
        cycle();
        check("fq_alu_resumed", wb_rd, 10);
        alu_valid = 0;
        cycle();
        check("fq_second_rd", wb_rd, 4);
        check("fq_second_data", wb_wdata, 32'hB);
        cycle();
        cycle();

        // Reset mid-traffic: two queued loads and x5 pending
        iss_set = 1; iss_rd = 5; chk_rs1 = 5;
        cycle();
        iss_set = 0;
        alu_valid = 1; alu_rd = 11; alu_data = 32'h1111;
        ld_valid = 1; ld_rd = 5; ld_data = 32'h5555;
        cycle();
        ld_rd = 6; ld_data = 32'h6666;
        cycle();
        clear_inputs();
        chk_rs1 = 5;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("mrst_we", wb_we, 0);
        check("mrst_idle", idle, 1);
        check("mrst_busy5", busy1, 0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("mrst_no_write", wb_we, 0);
        end

        // Mixed random stream of 20 results
        produced = 0;
        cyc = 0;
        while ((produced < 20 || alu_valid || ld_valid) && cyc < 400) begin
            iss_set = 0;
            chk_rs1 = 5'($urandom_range(0, 31));
            chk_rs2 = 5'($urandom_range(0, 31));
            if (!alu_valid && produced < 20 && $urandom_range(0, 1) == 1) begin
                alu_valid = 1;
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
                iss_set   = 1;
                iss_rd    = alu_rd;
                produced++;
            end
            if (!ld_valid && produced < 20 && $urandom_range(0, 2) != 0) begin
                ld_valid = 1;
                ld_rd    = 5'($urandom_range(0, 31));
                ld_data  = $urandom;
                if (!iss_set) begin
                    iss_set = 1;
                    iss_rd  = ld_rd;
                end
                produced++;
            end
            cycle();
            if (m_alu_acc) alu_valid = 0;
            if (m_ld_acc)  ld_valid  = 0;
            cyc++;
        end
        check("mix_all_accepted", {alu_valid, ld_valid}, 2'b00);
        clear_inputs();
        for (int i = 0; i < 50 && !m_idle(); i++) cycle();
        cycle();
        check("mix_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
